// File: rtl/saes_decrypt_fsm.sv
// Sequencing controller for the simplified-AES decryption datapath.
// Expands the whole key schedule first, then walks the round keys downward.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for load, all strobes low
// LOAD_CT    | capture ciphertext (one cycle)
// KEY_EXPAND | key schedule running until key_expand_done
// ADD_KEY    | XOR state with round key key_sel (one cycle)
// INV_SHIFT  | InvShiftRow running until inv_shift_done
// INV_NIBBLE | InvNibbleSub running; exit decrements the round counter
// INV_MIX    | InvMixColumn running until inv_mix_done
// DONE       | plaintext valid, held until result_ack
module saes_decrypt_fsm #(
    parameter int NUM_ROUNDS = 2,
    parameter int RW         = 2
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          load,
    input  logic          key_expand_done,
    input  logic          inv_shift_done,
    input  logic          inv_nibble_done,
    input  logic          inv_mix_done,
    input  logic          result_ack,
    output logic          load_cipher,
    output logic          load_key_expand,
    output logic          load_inv_shift,
    output logic          load_inv_nibble,
    output logic          load_inv_mix,
    output logic          load_adding_key,
    output logic [RW-1:0] key_sel,
    output logic          get_result,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_CT    = 3'd1,
        KEY_EXPAND = 3'd2,
        ADD_KEY    = 3'd3,
        INV_SHIFT  = 3'd4,
        INV_NIBBLE = 3'd5,
        INV_MIX    = 3'd6,
        DONE       = 3'd7
    } state_t;

    localparam logic [RW-1:0] CNT_INIT = RW'(NUM_ROUNDS);

    state_t        state, state_nxt;
    logic [RW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            cnt   <= CNT_INIT;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = IDLE;
        cnt_nxt         = cnt;
        load_cipher     = 1'b0;
        load_key_expand = 1'b0;
        load_inv_shift  = 1'b0;
        load_inv_nibble = 1'b0;
        load_inv_mix    = 1'b0;
        load_adding_key = 1'b0;
        get_result      = 1'b0;
        busy            = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = load ? LOAD_CT : IDLE;
            end
            LOAD_CT: begin
                load_cipher = 1'b1;
                busy        = 1'b1;
                state_nxt   = KEY_EXPAND;
            end
            KEY_EXPAND: begin
                load_key_expand = 1'b1;
                busy            = 1'b1;
                state_nxt       = key_expand_done ? ADD_KEY : KEY_EXPAND;
            end
            ADD_KEY: begin
                load_adding_key = 1'b1;
                busy            = 1'b1;
                // First key add is the whitening step, so no InvMixColumn before it.
                if (cnt == CNT_INIT)
                    state_nxt = INV_SHIFT;
                else if (cnt == '0)
                    state_nxt = DONE;
                else
                    state_nxt = INV_MIX;
            end
            INV_SHIFT: begin
                load_inv_shift = 1'b1;
                busy           = 1'b1;
                state_nxt      = inv_shift_done ? INV_NIBBLE : INV_SHIFT;
            end
            INV_NIBBLE: begin
                load_inv_nibble = 1'b1;
                busy            = 1'b1;
                if (inv_nibble_done) begin
                    state_nxt = ADD_KEY;
                    if (cnt != '0)
                        cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = INV_NIBBLE;
                end
            end
            INV_MIX: begin
                load_inv_mix = 1'b1;
                busy         = 1'b1;
                state_nxt    = inv_mix_done ? INV_SHIFT : INV_MIX;
            end
            DONE: begin
                get_result = 1'b1;
                busy       = 1'b1;
                if (result_ack) begin
                    state_nxt = IDLE;
                    cnt_nxt   = CNT_INIT;
                end else begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign key_sel = cnt;

endmodule

// File: tb/tb_saes_decrypt_fsm.sv
// Bench for saes_decrypt_fsm: two instances (2 and 4 rounds) share stimulus and
// are compared every cycle against a queue-of-steps reference model.
module tb_saes_decrypt_fsm;

    logic clk;
    logic nrst;
    logic load, key_expand_done, inv_shift_done, inv_nibble_done, inv_mix_done, result_ack;

    logic load_cipher0, load_key_expand0, load_inv_shift0, load_inv_nibble0;
    logic load_inv_mix0, load_adding_key0, get_result0, busy0;
    logic [1:0] key_sel0;
    logic load_cipher1, load_key_expand1, load_inv_shift1, load_inv_nibble1;
    logic load_inv_mix1, load_adding_key1, get_result1, busy1;
    logic [2:0] key_sel1;

    int n_chk = 0;
    int n_bad = 0;

    saes_decrypt_fsm #(.NUM_ROUNDS(2), .RW(2)) u_dut0 (
        .clk(clk), .nrst(nrst), .load(load),
        .key_expand_done(key_expand_done), .inv_shift_done(inv_shift_done),
        .inv_nibble_done(inv_nibble_done), .inv_mix_done(inv_mix_done),
        .result_ack(result_ack),
        .load_cipher(load_cipher0), .load_key_expand(load_key_expand0),
        .load_inv_shift(load_inv_shift0), .load_inv_nibble(load_inv_nibble0),
        .load_inv_mix(load_inv_mix0), .load_adding_key(load_adding_key0),
        .key_sel(key_sel0), .get_result(get_result0), .busy(busy0)
    );

    saes_decrypt_fsm #(.NUM_ROUNDS(4), .RW(3)) u_dut1 (
        .clk(clk), .nrst(nrst), .load(load),
        .key_expand_done(key_expand_done), .inv_shift_done(inv_shift_done),
        .inv_nibble_done(inv_nibble_done), .inv_mix_done(inv_mix_done),
        .result_ack(result_ack),
        .load_cipher(load_cipher1), .load_key_expand(load_key_expand1),
        .load_inv_shift(load_inv_shift1), .load_inv_nibble(load_inv_nibble1),
        .load_inv_mix(load_inv_mix1), .load_adding_key(load_adding_key1),
        .key_sel(key_sel1), .get_result(get_result1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Step kinds; strobe bit for kind k is 6-k in {cipher,kexp,shift,nib,mix,add,result}.
    localparam int K_LOAD = 0, K_KEY = 1, K_SHIFT = 2, K_NIB = 3, K_MIX = 4, K_ADD = 5, K_DONE = 6;

    int q_kind [2][$];
    int q_key  [2][$];

    function automatic int nr(input int m);
        return (m == 0) ? 2 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_clear(input int m);
        q_kind[m].delete();
        q_key[m].delete();
    endtask

    task automatic model_build(input int m);
        int n;
        n = nr(m);
        q_kind[m].push_back(K_LOAD); q_key[m].push_back(n);
        q_kind[m].push_back(K_KEY);  q_key[m].push_back(n);
        q_kind[m].push_back(K_ADD);  q_key[m].push_back(n);
        for (int r = n; r >= 1; r--) begin
            if (r < n) begin
                q_kind[m].push_back(K_MIX); q_key[m].push_back(r);
            end
            q_kind[m].push_back(K_SHIFT); q_key[m].push_back(r);
            q_kind[m].push_back(K_NIB);   q_key[m].push_back(r);
            q_kind[m].push_back(K_ADD);   q_key[m].push_back(r - 1);
        end
        q_kind[m].push_back(K_DONE); q_key[m].push_back(0);
    endtask

    task automatic model_step(input int m);
        bit adv;
        if (!nrst) begin
            model_clear(m);
        end else if (q_kind[m].size() == 0) begin
            if (load) model_build(m);
        end else begin
            case (q_kind[m][0])
                K_KEY:   adv = key_expand_done;
                K_SHIFT: adv = inv_shift_done;
                K_NIB:   adv = inv_nibble_done;
                K_MIX:   adv = inv_mix_done;
                K_DONE:  adv = result_ack;
                default: adv = 1'b1;
            endcase
            if (adv) begin
                void'(q_kind[m].pop_front());
                void'(q_key[m].pop_front());
            end
        end
    endtask

    function automatic logic [6:0] obs_vec(input int m);
        if (m == 0)
            return {load_cipher0, load_key_expand0, load_inv_shift0, load_inv_nibble0,
                    load_inv_mix0, load_adding_key0, get_result0};
        return {load_cipher1, load_key_expand1, load_inv_shift1, load_inv_nibble1,
                load_inv_mix1, load_adding_key1, get_result1};
    endfunction

    task automatic check_all();
        logic [6:0] exp_v;
        int exp_k, exp_b;
        for (int m = 0; m < 2; m++) begin
            if (q_kind[m].size() == 0) begin
                exp_v = '0;
                exp_k = nr(m);
                exp_b = 0;
            end else begin
                exp_v = 7'd1 << (6 - q_kind[m][0]);
                exp_k = q_key[m][0];
                exp_b = 1;
            end
            chk($sformatf("strobes%0d", m), 32'(obs_vec(m)), 32'(exp_v));
            chk($sformatf("key_sel%0d", m), (m == 0) ? 32'(key_sel0) : 32'(key_sel1), exp_k);
            chk($sformatf("busy%0d", m), (m == 0) ? 32'(busy0) : 32'(busy1), exp_b);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    task automatic set_dones(input bit v);
        key_expand_done = v;
        inv_shift_done  = v;
        inv_nibble_done = v;
        inv_mix_done    = v;
    endtask

    task automatic drain();
        load = 1'b0;
        set_dones(1'b1);
        result_ack = 1'b1;
        repeat (30) cycle();
        result_ack = 1'b0;
    endtask

    // Pulses load, then counts edges until each instance raises get_result.
    task automatic run_latency(input string tag, input int exp0, input int exp1, input bit stall);
        int lat0, lat1, ke, mx;
        lat0 = -1; lat1 = -1; ke = 0; mx = 0;
        load = 1'b1;
        cycle();
        load = 1'b0;
        for (int i = 1; i <= 80 && (lat0 < 0 || (exp1 >= 0 && lat1 < 0)); i++) begin
            if (stall) begin
                key_expand_done = (ke >= 5);
                inv_mix_done    = (mx >= 3);
            end
            cycle();
            if (get_result0 && lat0 < 0) lat0 = i;
            if (get_result1 && lat1 < 0) lat1 = i;
            ke = load_key_expand0 ? ke + 1 : 0;
            mx = load_inv_mix0 ? mx + 1 : 0;
        end
        chk({tag, "_lat0"}, lat0, exp0);
        if (exp1 >= 0) chk({tag, "_lat1"}, lat1, exp1);
    endtask

    initial begin
        bit found;
        nrst = 1'b0;
        load = 1'b0;
        result_ack = 1'b0;
        set_dones(1'b0);
        model_clear(0);
        model_clear(1);

        repeat (3) cycle();
        chk("rst_key0", key_sel0, 2);
        chk("rst_key1", key_sel1, 4);
        nrst = 1'b1;
        repeat (5) cycle();

        // All done inputs tied high: minimum latency.
        set_dones(1'b1);
        run_latency("happy", 10, 18, 1'b0);
        repeat (3) cycle();
        chk("held_result0", get_result0, 1);
        drain();

        // Stalled key expansion and InvMixColumn.
        set_dones(1'b1);
        key_expand_done = 1'b0;
        inv_mix_done    = 1'b0;
        run_latency("stall", 16, -1, 1'b1);
        drain();

        // load and result_ack together in DONE, then a fresh run.
        set_dones(1'b1);
        run_latency("b2b_a", 10, 18, 1'b0);
        load = 1'b1;
        result_ack = 1'b1;
        cycle();
        load = 1'b0;
        result_ack = 1'b0;
        chk("b2b_idle0", busy0, 0);
        cycle();
        chk("b2b_still_idle1", busy1, 0);
        run_latency("b2b_b", 10, 18, 1'b0);
        drain();

        // Asynchronous reset while in INV_MIX.
        set_dones(1'b1);
        inv_mix_done = 1'b0;
        load = 1'b1;
        cycle();
        load = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            found = load_inv_mix0;
        end
        chk("mix_reached", found, 1);
        chk("mix_key0", key_sel0, 1);
        #3;
        nrst = 1'b0;
        model_clear(0);
        model_clear(1);
        #1;
        check_all();
        chk("async_busy0", busy0, 0);
        chk("async_key0", key_sel0, 2);
        cycle();
        nrst = 1'b1;
        set_dones(1'b1);
        run_latency("post_rst", 10, 18, 1'b0);
        drain();

        // Random done, load and ack traffic including spurious pulses.
        for (int i = 0; i < 600; i++) begin
            load            = ($urandom_range(0, 7) == 0);
            key_expand_done = ($urandom_range(0, 2) != 0);
            inv_shift_done  = ($urandom_range(0, 2) != 0);
            inv_nibble_done = ($urandom_range(0, 2) != 0);
            inv_mix_done    = ($urandom_range(0, 2) != 0);
            result_ack      = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
